tsu_stamp_queue: RTL and testbench



---
 rtl/tsu_stamp_queue.sv | 169 ++++++++++++++++
 tb/tb_tsu_stamp_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tsu_stamp_queue.sv
// GMII time-stamp queue: stamps each start-of-frame with latency-corrected RTC time and
// queues {info, stamp} on PTP parser matches. Define TSU_DROP_OLDEST_EN to overwrite the oldest entry when full.
module tsu_stamp_queue #(
  parameter int unsigned TS_WIDTH   = 32,
  parameter int unsigned INFO_WIDTH = 20,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned TS_ADJ     = 0
) (
  input  logic                           gmii_clk,
  input  logic                           rst,
  input  logic                           gmii_ctrl,
  input  logic [TS_WIDTH-1:0]            rtc_time_in,
  input  logic                           ptp_found,
  input  logic [INFO_WIDTH-1:0]          ptp_infor,
  input  logic                           q_clr,
  input  logic                           q_rd_en,
  output logic [INFO_WIDTH+TS_WIDTH-1:0] q_rd_data,
  output logic                           q_rd_valid,
  output logic [7:0]                     q_rd_stat,
  output logic                           q_empty,
  output logic                           q_full,
  output logic [15:0]                    q_ovf_cnt
);

  localparam int unsigned DW    = INFO_WIDTH + TS_WIDTH;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [TS_WIDTH-1:0]   TS_ADJ_V = TS_WIDTH'(TS_ADJ);
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
`ifdef TSU_DROP_OLDEST_EN
  localparam bit DROP_OLDEST = 1'b1;
`else
  localparam bit DROP_OLDEST = 1'b0;
`endif

  logic                  ctrl_d1_q, ctrl_d1_d;
  logic [TS_WIDTH-1:0]   stamp_q, stamp_d;
  logic                  stamp_vld_q, stamp_vld_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   usedw_q, usedw_d;
  logic                  ovf_q, ovf_d;
  logic [15:0]           ovf_cnt_q, ovf_cnt_d;
  logic [DW-1:0]         rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic [DW-1:0] mem [DEPTH];

  logic          sof;
  logic          wr_req;
  logic          is_empty;
  logic          is_full;
  logic          do_rd;
  logic          do_wr;
  logic          ovf_ev;
  logic          mem_we;
  logic [DW-1:0] wr_data;

  assign sof      = gmii_ctrl & ~ctrl_d1_q;
  assign wr_req   = ptp_found & stamp_vld_q;
  assign wr_data  = {ptp_infor, stamp_q};
  assign is_empty = (usedw_q == '0);
  assign is_full  = (usedw_q == FULL_LVL);
  assign do_rd    = q_rd_en & ~is_empty;
  // A pop in the same cycle as a full-queue write frees the slot the write needs.
  assign do_wr    = wr_req & (~is_full | do_rd);
  assign ovf_ev   = wr_req & is_full & ~do_rd;
  assign mem_we   = ~q_clr & (do_wr | (ovf_ev & DROP_OLDEST));

  always_comb begin
    ctrl_d1_d   = gmii_ctrl;
    stamp_d     = stamp_q;
    stamp_vld_d = stamp_vld_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    usedw_d     = usedw_q;
    ovf_d       = ovf_q;
    ovf_cnt_d   = ovf_cnt_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;

    if (sof) begin
      stamp_d = rtc_time_in - TS_ADJ_V;
    end

    if (q_clr) begin
      stamp_vld_d = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      usedw_d     = '0;
      ovf_d       = 1'b0;
      ovf_cnt_d   = '0;
    end else begin
      // A same-cycle SOF reloads the stamp after the old one has been consumed.
      if (sof) begin
        stamp_vld_d = 1'b1;
      end else if (wr_req) begin
        stamp_vld_d = 1'b0;
      end

      if (do_rd) begin
        rd_data_d  = mem[rd_ptr_q];
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + 1'b1;
      end

      if (do_wr) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (ovf_ev) begin
        ovf_d = 1'b1;
        if (ovf_cnt_q != 16'hFFFF) begin
          ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
        if (DROP_OLDEST) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end

      case ({do_wr, do_rd})
        2'b10:   usedw_d = usedw_q + 1'b1;
        2'b01:   usedw_d = usedw_q - 1'b1;
        default: usedw_d = usedw_q;
      endcase
    end
  end

  always_ff @(posedge gmii_clk) begin
    if (rst) begin
      ctrl_d1_q   <= 1'b0;
      stamp_q     <= '0;
      stamp_vld_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      usedw_q     <= '0;
      ovf_q       <= 1'b0;
      ovf_cnt_q   <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      ctrl_d1_q   <= ctrl_d1_d;
      stamp_q     <= stamp_d;
      stamp_vld_q <= stamp_vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      usedw_q     <= usedw_d;
      ovf_q       <= ovf_d;
      ovf_cnt_q   <= ovf_cnt_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Storage is not reset; usedw alone decides which entries are live.
  always_ff @(posedge gmii_clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign q_rd_data  = rd_data_q;
  assign q_rd_valid = rd_valid_q;
  assign q_rd_stat  = {ovf_q, 7'(usedw_q)};
  assign q_empty    = is_empty;
  assign q_full     = is_full;
  assign q_ovf_cnt  = ovf_cnt_q;

endmodule

// File: tb/tb_tsu_stamp_queue.sv
// Self-checking bench for tsu_stamp_queue: directed steps with a scoreboard queue of expected pops.
module tb_tsu_stamp_queue;

  localparam int TSW    = 32;
  localparam int INW    = 20;
  localparam int DLOG   = 4;
  localparam int DEPTH  = 1 << DLOG;
  localparam int TS_ADJ = 5;

  logic                 gmii_clk = 1'b0;
  logic                 rst;
  logic                 gmii_ctrl;
  logic [TSW-1:0]       rtc_time_in;
  logic                 ptp_found;
  logic [INW-1:0]       ptp_infor;
  logic                 q_clr;
  logic                 q_rd_en;
  logic [INW+TSW-1:0]   q_rd_data;
  logic                 q_rd_valid;
  logic [7:0]           q_rd_stat;
  logic                 q_empty;
  logic                 q_full;
  logic [15:0]          q_ovf_cnt;

  int checks = 0;
  int failures = 0;

  logic [INW+TSW-1:0] sb[$];
  logic [INW+TSW-1:0] lastData = '0;
  int                 modelOvfCnt = 0;
  logic               modelOvf = 1'b0;

  tsu_stamp_queue #(
    .TS_WIDTH(TSW), .INFO_WIDTH(INW), .DEPTH_LOG2(DLOG), .TS_ADJ(TS_ADJ)
  ) dut (
    .gmii_clk(gmii_clk), .rst(rst), .gmii_ctrl(gmii_ctrl), .rtc_time_in(rtc_time_in),
    .ptp_found(ptp_found), .ptp_infor(ptp_infor), .q_clr(q_clr), .q_rd_en(q_rd_en),
    .q_rd_data(q_rd_data), .q_rd_valid(q_rd_valid), .q_rd_stat(q_rd_stat),
    .q_empty(q_empty), .q_full(q_full), .q_ovf_cnt(q_ovf_cnt)
  );

  always #5 gmii_clk = ~gmii_clk;

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge gmii_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [INW+TSW-1:0] mkEntry(input logic [TSW-1:0] ts, input logic [INW-1:0] info);
    logic [TSW-1:0] s;
    s = ts - TSW'(TS_ADJ);
    return {info, s};
  endfunction

  // Model an accepted write request against the scoreboard occupancy.
  task automatic modelWrite(input logic [INW+TSW-1:0] e);
    if (sb.size() < DEPTH) begin
      sb.push_back(e);
    end else begin
      modelOvf = 1'b1;
      if (modelOvfCnt < 16'hFFFF) modelOvfCnt++;
`ifdef TSU_DROP_OLDEST_EN
      void'(sb.pop_front());
      sb.push_back(e);
`endif
    end
  endtask

  function automatic logic [7:0] expStat();
    return {modelOvf, 7'(sb.size())};
  endfunction

  // One frame: rising RX_DV, then a parser match, then RX_DV low.
  task automatic applyStimulus(input logic [TSW-1:0] ts, input logic [INW-1:0] info);
    gmii_ctrl = 1'b1; rtc_time_in = ts;
    tick();
    ptp_found = 1'b1; ptp_infor = info; rtc_time_in = ts + 32'd77;
    tick();
    modelWrite(mkEntry(ts, info));
    ptp_found = 1'b0; gmii_ctrl = 1'b0;
    tick();
  endtask

  task automatic popAndCheck(input string tag);
    logic [INW+TSW-1:0] exp;
    logic               expV;
    expV = (sb.size() > 0);
    exp  = expV ? sb.pop_front() : lastData;
    q_rd_en = 1'b1;
    tick();
    q_rd_en = 1'b0;
    checkOutput({tag, "_valid"}, 64'(q_rd_valid), 64'(expV));
    checkOutput({tag, "_data"}, 64'(q_rd_data), 64'(exp));
    lastData = exp;
  endtask

  initial begin
    logic [INW+TSW-1:0] e;
    logic [TSW-1:0]     tsA, tsB;

    rst = 1'b1; gmii_ctrl = 1'b0; rtc_time_in = '0; ptp_found = 1'b0;
    ptp_infor = '0; q_clr = 1'b0; q_rd_en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("rst_empty", 64'(q_empty), 64'd1);
    checkOutput("rst_full", 64'(q_full), 64'd0);
    checkOutput("rst_stat", 64'(q_rd_stat), 64'd0);
    checkOutput("rst_ovfcnt", 64'(q_ovf_cnt), 64'd0);
    checkOutput("rst_valid", 64'(q_rd_valid), 64'd0);
    checkOutput("rst_data", 64'(q_rd_data), 64'd0);

    $display("[TB] stamp and pop");
    applyStimulus(32'd100, 20'hABCDE);
    checkOutput("one_stat", 64'(q_rd_stat), 64'h01);
    checkOutput("stamp_model", 64'(sb[0]), {12'h0, 20'hABCDE, 32'd95});
    popAndCheck("pop1");
    checkOutput("pop1_empty", 64'(q_empty), 64'd1);
    tick();
    checkOutput("pop1_valid_drop", 64'(q_rd_valid), 64'd0);
    checkOutput("pop1_hold", 64'(q_rd_data), 64'(lastData));

    $display("[TB] unmatched found");
    ptp_found = 1'b1; ptp_infor = 20'h11111;
    tick();
    ptp_found = 1'b0;
    tick();
    checkOutput("nosof_stat", 64'(q_rd_stat), 64'h00);
    checkOutput("nosof_ovfcnt", 64'(q_ovf_cnt), 64'd0);
    applyStimulus(32'd500, 20'h22222);
    ptp_found = 1'b1; ptp_infor = 20'h33333;
    tick();
    ptp_found = 1'b0;
    tick();
    checkOutput("second_found_stat", 64'(q_rd_stat), 64'h01);
    popAndCheck("pop_single");
    popAndCheck("pop_empty");

    $display("[TB] fill and overflow");
    for (int i = 1; i <= 18; i++) applyStimulus(32'd1000 + 32'(i), 20'(i));
    checkOutput("fill_full", 64'(q_full), 64'd1);
    checkOutput("fill_stat", 64'(q_rd_stat), 64'h90);
    checkOutput("fill_ovfcnt", 64'(q_ovf_cnt), 64'd2);

    $display("[TB] full with pop and write together");
    tsA = 32'd7000;
    gmii_ctrl = 1'b1; rtc_time_in = tsA;
    tick();
    e = sb.pop_front();
    sb.push_back(mkEntry(tsA, 20'h55555));
    ptp_found = 1'b1; ptp_infor = 20'h55555; q_rd_en = 1'b1;
    tick();
    ptp_found = 1'b0; q_rd_en = 1'b0; gmii_ctrl = 1'b0;
    checkOutput("rw_full_valid", 64'(q_rd_valid), 64'd1);
    checkOutput("rw_full_data", 64'(q_rd_data), 64'(e));
    lastData = e;
    tick();
    checkOutput("rw_full_stat", 64'(q_rd_stat), 64'h90);
    checkOutput("rw_full_ovfcnt", 64'(q_ovf_cnt), 64'd2);
    for (int i = 0; i < DEPTH; i++) popAndCheck($sformatf("drain%0d", i));
    checkOutput("drain_empty", 64'(q_empty), 64'd1);
    checkOutput("drain_stat", 64'(q_rd_stat), 64'h80);

    $display("[TB] flush and wrap");
    gmii_ctrl = 1'b1; rtc_time_in = 32'd9000;
    tick();
    ptp_found = 1'b1; ptp_infor = 20'h77777; q_clr = 1'b1;
    tick();
    ptp_found = 1'b0; q_clr = 1'b0; gmii_ctrl = 1'b0;
    sb.delete(); modelOvf = 1'b0; modelOvfCnt = 0;
    tick();
    checkOutput("clr_stat", 64'(q_rd_stat), 64'h00);
    checkOutput("clr_ovfcnt", 64'(q_ovf_cnt), 64'd0);
    checkOutput("clr_empty", 64'(q_empty), 64'd1);
    checkOutput("clr_hold", 64'(q_rd_data), 64'(lastData));
    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom, 20'($urandom));
      if (i % 3 != 0) popAndCheck($sformatf("wrap%0d", i));
    end
    checkOutput("wrap_stat", 64'(q_rd_stat), 64'(expStat()));
    while (sb.size() > 0) popAndCheck("wrap_drain");
    checkOutput("wrap_empty", 64'(q_empty), 64'd1);

    $display("[TB] same-cycle SOF and found");
    tsA = 32'h0000_0003;
    tsB = 32'h1234_5678;
    gmii_ctrl = 1'b1; rtc_time_in = tsA;
    tick();
    gmii_ctrl = 1'b0;
    tick();
    gmii_ctrl = 1'b1; rtc_time_in = tsB; ptp_found = 1'b1; ptp_infor = 20'hC0FFE;
    sb.push_back(mkEntry(tsA, 20'hC0FFE));
    tick();
    rtc_time_in = 32'hDEAD_BEEF; ptp_infor = 20'hBEEF1;
    sb.push_back(mkEntry(tsB, 20'hBEEF1));
    tick();
    ptp_found = 1'b0; gmii_ctrl = 1'b0;
    tick();
    checkOutput("same_stat", 64'(q_rd_stat), 64'h02);
    popAndCheck("same_old");
    popAndCheck("same_new");
    checkOutput("final_ovfcnt", 64'(q_ovf_cnt), 64'(modelOvfCnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
